// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with one outstanding imem request, skid buffer and redirect/cancel.
// Optional FETCH_ALIGN_CHECK_EN reports misaligned redirect targets instead of masking them.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_addr_err,
`endif
  output logic [31:0] if_inst
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DRAIN, ERR} state_t;
  state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic [31:0] skid_pc_q, skid_pc_d, skid_inst_q, skid_inst_d;
  logic [31:0] if_pc_q, if_pc_d, if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;
  logic        slot_free, inflight;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        err_q, err_d, drop_q, drop_d;
  assign fetch_addr_err = err_q;
`endif
  assign imem_req  = state_q == REQ;
  assign imem_addr = fetch_pc_q;
  assign if_valid  = if_valid_q;
  assign if_pc     = if_pc_q;
  assign if_inst   = if_inst_q;
  assign slot_free = ~if_valid_q | ~stall;
  // A response is still owed by memory if a grant just happened or one is pending.
  always_comb begin
    inflight = (state_q == REQ && imem_gnt) || ((state_q == WAIT || state_q == DRAIN) && !imem_rvalid);
`ifdef FETCH_ALIGN_CHECK_EN
    inflight = inflight || (state_q == ERR && drop_q && !imem_rvalid);
`endif
  end
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if_valid_d  = if_valid_q & stall;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
`ifdef FETCH_ALIGN_CHECK_EN
    err_d  = err_q;
    drop_d = drop_q & ~imem_rvalid;
`endif
    case (state_q)
      BOOT: state_d = REQ;
      REQ: if (imem_gnt) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_INC;
        state_d    = WAIT;
      end
      WAIT: if (imem_rvalid) begin
        if (slot_free) begin
          if_valid_d = 1'b1;
          if_pc_d    = req_pc_q;
          if_inst_d  = imem_rdata;
          state_d    = REQ;
        end else begin
          skid_pc_d   = req_pc_q;
          skid_inst_d = imem_rdata;
          state_d     = HOLD;
        end
      end
      HOLD: if (!stall) begin
        if_valid_d = 1'b1;
        if_pc_d    = skid_pc_q;
        if_inst_d  = skid_inst_q;
        state_d    = REQ;
      end
      DRAIN: if (imem_rvalid) state_d = REQ;
      default: ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      if_valid_d = 1'b0;
      state_d    = inflight ? DRAIN : REQ;
`ifdef FETCH_ALIGN_CHECK_EN
      err_d  = 1'b0;
      drop_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = ERR;
        err_d      = 1'b1;
        drop_d     = inflight;
        if_valid_d = 1'b1;
        if_pc_d    = redirect_pc;
        if_inst_d  = 32'h0;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= RESET_PC;
      if_inst_q   <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q       <= 1'b0;
      drop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
`ifdef FETCH_ALIGN_CHECK_EN
      err_q       <= err_d;
      drop_q      <= drop_d;
`endif
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl with a latency-programmable memory model.
module tb_fetch_ctrl;
  localparam logic [31:0] K  = 32'h12345678;
  localparam logic [31:0] RP = 32'h00400000;
  logic        clk = 0, reset = 1, stall = 0, redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic        imem_req, imem_gnt, imem_rvalid, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_pc, if_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_addr_err;
`endif
  int checks = 0, errors = 0;
  logic gnt_en = 1, pend = 0;
  int lat = 1, cnt = 0;
  logic [31:0] paddr = 0;
  logic [31:0] gnt_log[$], acc_pc[$], acc_inst[$];

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_pc(if_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_addr_err(fetch_addr_err),
`endif
    .if_inst(if_inst)
  );

  always #5 clk = ~clk;
  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = pend && cnt == 0;
  assign imem_rdata  = imem_rvalid ? (paddr ^ K) : 32'h0;

  always @(posedge clk) begin
    if (imem_rvalid) pend <= 0;
    else if (pend) cnt <= cnt - 1;
    if (imem_gnt && !reset) begin
      pend <= 1;
      cnt <= lat - 1;
      paddr <= imem_addr;
      gnt_log.push_back(imem_addr);
    end
    if (if_valid && !stall && !reset) begin
      acc_pc.push_back(if_pc);
      acc_inst.push_back(if_inst);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1; stall = 0; redirect_valid = 0; gnt_en = 1;
    repeat (4) @(negedge clk);
    reset = 0;
    gnt_log.delete(); acc_pc.delete(); acc_inst.delete();
  endtask

  task automatic wait_acc(input int n);
    for (int t = 0; t < 40 && acc_pc.size() < n; t++) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", if_valid); end
    checks++; if (if_pc !== RP) begin errors++; $display("FAIL reset_pc: got %h exp %h", if_pc, RP); end
    checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h exp 0", if_inst); end
    checks++; if (imem_addr !== RP) begin errors++; $display("FAIL reset_addr: got %h exp %h", imem_addr, RP); end
`ifdef FETCH_ALIGN_CHECK_EN
    checks++; if (fetch_addr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", fetch_addr_err); end
`endif
  endtask

  task automatic test_sequential();
    do_reset(); lat = 1;
    wait_acc(3);
    checks++; if (acc_pc.size() < 3) begin errors++; $display("FAIL seq_count: got %0d exp 3", acc_pc.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (gnt_log[i] !== RP + 4 * i) begin errors++; $display("FAIL seq_addr%0d: got %h exp %h", i, gnt_log[i], RP + 4 * i); end
      checks++; if (acc_pc[i] !== RP + 4 * i) begin errors++; $display("FAIL seq_pc%0d: got %h exp %h", i, acc_pc[i], RP + 4 * i); end
      checks++; if (acc_inst[i] !== ((RP + 4 * i) ^ K)) begin errors++; $display("FAIL seq_inst%0d: got %h exp %h", i, acc_inst[i], (RP + 4 * i) ^ K); end
    end
  endtask

  task automatic reach_stalled(input logic [31:0] pc);
    for (int t = 0; t < 40 && !(if_valid && if_pc == pc); t++) @(negedge clk);
    stall = 1;
  endtask

  task automatic test_stall();
    do_reset(); lat = 1;
    reach_stalled(32'h00400004);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({if_valid, if_pc, if_inst} !== {1'b1, 32'h00400004, 32'h00400004 ^ K}) begin
        errors++; $display("FAIL stall_hold%0d: got %b %h %h exp 1 00400004 %h", i, if_valid, if_pc, if_inst, 32'h00400004 ^ K);
      end
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_noreq: got %b exp 0", imem_req); end
    checks++; if (gnt_log.size() != 3) begin errors++; $display("FAIL stall_gnts: got %0d exp 3", gnt_log.size()); end
    stall = 0;
    @(negedge clk);
    checks++; if ({if_valid, if_pc} !== {1'b1, 32'h00400008}) begin errors++; $display("FAIL skid_out: got %b %h exp 1 00400008", if_valid, if_pc); end
    checks++; if (if_inst !== (32'h00400008 ^ K)) begin errors++; $display("FAIL skid_inst: got %h exp %h", if_inst, 32'h00400008 ^ K); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0040000C}) begin errors++; $display("FAIL skid_resume: got %b %h exp 1 0040000c", imem_req, imem_addr); end
    checks++; if (acc_pc.size() != 2) begin errors++; $display("FAIL stall_once: got %0d accepted exp 2", acc_pc.size()); end
  endtask

  task automatic test_redirect_stall();
    do_reset(); lat = 1;
    reach_stalled(32'h00400004);
    repeat (3) @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h00400500;
    @(negedge clk);
    redirect_valid = 0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rs_flush: got %b exp 0", if_valid); end
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h00400500}) begin errors++; $display("FAIL rs_req: got %b %h exp 1 00400500", imem_req, imem_addr); end
    stall = 0;
    wait_acc(2);
    checks++; if (acc_pc[1] !== 32'h00400500) begin errors++; $display("FAIL rs_next: got %h exp 00400500", acc_pc[1]); end
  endtask

  task automatic test_redirect_wait();
    do_reset(); lat = 3;
    repeat (2) @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h00400100;
    @(negedge clk);
    redirect_valid = 0;
    wait_acc(1);
    checks++; if (acc_pc[0] !== 32'h00400100) begin errors++; $display("FAIL rw_pc: got %h exp 00400100", acc_pc[0]); end
    checks++; if (acc_inst[0] !== (32'h00400100 ^ K)) begin errors++; $display("FAIL rw_inst: got %h exp %h", acc_inst[0], 32'h00400100 ^ K); end
    checks++; if (gnt_log[1] !== 32'h00400100) begin errors++; $display("FAIL rw_addr: got %h exp 00400100", gnt_log[1]); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(); lat = 1;
    repeat (2) @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h00400200;
    @(negedge clk);
    redirect_valid = 0;
    wait_acc(1);
    checks++; if (acc_pc[0] !== 32'h00400200) begin errors++; $display("FAIL rr_pc: got %h exp 00400200", acc_pc[0]); end
    checks++; if (gnt_log[1] !== 32'h00400200) begin errors++; $display("FAIL rr_addr: got %h exp 00400200", gnt_log[1]); end
  endtask

  task automatic test_redirect_gnt();
    do_reset(); lat = 2;
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'h00400300;
    @(negedge clk);
    redirect_valid = 0;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rg_drain: got %b exp 0", imem_req); end
    wait_acc(1);
    checks++; if (acc_pc[0] !== 32'h00400300) begin errors++; $display("FAIL rg_pc: got %h exp 00400300", acc_pc[0]); end
    checks++; if (gnt_log[1] !== 32'h00400300) begin errors++; $display("FAIL rg_addr: got %h exp 00400300", gnt_log[1]); end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 1;
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 32'hFFFFFFFC;
    @(negedge clk);
    redirect_valid = 0;
    wait_acc(2);
    checks++; if (acc_pc[0] !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc0: got %h exp fffffffc", acc_pc[0]); end
    checks++; if (acc_pc[1] !== 32'h00000000) begin errors++; $display("FAIL wrap_pc1: got %h exp 00000000", acc_pc[1]); end
    checks++; if (acc_inst[1] !== K) begin errors++; $display("FAIL wrap_inst: got %h exp %h", acc_inst[1], K); end
  endtask

  task automatic test_reset_wait();
    do_reset(); lat = 3;
    repeat (2) @(negedge clk);
    reset = 1;
    #1;
    checks++; if ({imem_req, if_valid} !== 2'b00) begin errors++; $display("FAIL rstw_async: got %b%b exp 00", imem_req, if_valid); end
    repeat (4) @(negedge clk);
    reset = 0;
    gnt_log.delete(); acc_pc.delete(); acc_inst.delete();
    wait_acc(1);
    checks++; if (gnt_log[0] !== RP) begin errors++; $display("FAIL rstw_addr: got %h exp %h", gnt_log[0], RP); end
    checks++; if (acc_pc[0] !== RP) begin errors++; $display("FAIL rstw_pc: got %h exp %h", acc_pc[0], RP); end
    checks++; if (acc_inst[0] !== (RP ^ K)) begin errors++; $display("FAIL rstw_inst: got %h exp %h", acc_inst[0], RP ^ K); end
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  task automatic test_align();
    do_reset(); lat = 1;
    @(negedge clk);
    gnt_en = 0; redirect_valid = 1; redirect_pc = 32'h00400102;
    @(negedge clk);
    redirect_valid = 0; gnt_en = 1;
    checks++;
    if ({if_valid, if_pc, if_inst, fetch_addr_err, imem_req} !== {1'b1, 32'h00400102, 32'h0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL align_err: got %b %h %h %b %b exp 1 00400102 0 1 0", if_valid, if_pc, if_inst, fetch_addr_err, imem_req);
    end
    repeat (3) @(negedge clk);
    checks++; if ({imem_req, fetch_addr_err} !== 2'b01) begin errors++; $display("FAIL align_idle: got %b%b exp 01", imem_req, fetch_addr_err); end
    redirect_valid = 1; redirect_pc = 32'h00400200;
    @(negedge clk);
    redirect_valid = 0;
    checks++; if (fetch_addr_err !== 1'b0) begin errors++; $display("FAIL align_clear: got %b exp 0", fetch_addr_err); end
    wait_acc(2);
    checks++; if (acc_pc[1] !== 32'h00400200) begin errors++; $display("FAIL align_resume: got %h exp 00400200", acc_pc[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_gnt();
    test_wrap();
    test_reset_wait();
`ifdef FETCH_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
